// File: rtl/sdram_init_seq.sv
// SDRAM power-up init: NOP wait, PRECHARGE ALL, N_REF x AUTO REFRESH, LOAD MODE, then ofin.
// Optional macro SDRAM_INIT_REINIT_EN: ireq in DONE replays PRE/REF/MRS without the power-up wait.
module sdram_init_seq #(
  parameter int unsigned ADDR_W           = 13,
  parameter int unsigned BA_W             = 2,
  parameter int unsigned DQ_W             = 16,
  parameter int unsigned T_PWRUP          = 20000,
  parameter int unsigned T_RP             = 2,
  parameter int unsigned T_RFC            = 7,
  parameter int unsigned T_MRD            = 2,
  parameter int unsigned N_REF            = 8,
  parameter int unsigned CAS_LAT          = 2,
  parameter int unsigned BURST_CODE       = 0,
  parameter int unsigned BURST_INTERLEAVE = 0,
  parameter int unsigned WRITE_SINGLE     = 1
) (
  input  logic              iclk,
  input  logic              ctr_reset,
  input  logic              ireq,
  input  logic              ienb,
  output logic              ofin,
  output logic              obusy,
  output logic              DRAM_CLK,
  output logic              DRAM_CKE,
  output logic [ADDR_W-1:0] DRAM_ADDR,
  output logic [BA_W-1:0]   DRAM_BA,
  output logic              DRAM_CS_N,
  output logic              DRAM_RAS_N,
  output logic              DRAM_CAS_N,
  output logic              DRAM_WE_N,
  output logic              DRAM_LDQM,
  output logic              DRAM_UDQM,
  output logic [DQ_W-1:0]   DRAM_DQ
);

  localparam int unsigned TMaxA = (T_PWRUP > T_RP) ? T_PWRUP : T_RP;
  localparam int unsigned TMaxB = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int unsigned TMax  = (TMaxA > TMaxB) ? TMaxA : TMaxB;
  localparam int unsigned CntW  = $clog2(TMax + 1);
  localparam int unsigned RefW  = $clog2(N_REF + 1);

  localparam logic [CntW-1:0] PwrupLast = CntW'(T_PWRUP - 1);
  localparam logic [CntW-1:0] RpLast    = CntW'(T_RP - 1);
  localparam logic [CntW-1:0] RfcLast   = CntW'(T_RFC - 1);
  localparam logic [CntW-1:0] MrdLast   = CntW'(T_MRD - 1);
  localparam logic [RefW-1:0] NRef      = RefW'(N_REF);

  localparam logic [9:0] ModeBits = {1'(WRITE_SINGLE), 2'b00, 3'(CAS_LAT),
                                     1'(BURST_INTERLEAVE), 3'(BURST_CODE)};
  localparam logic [ADDR_W-1:0] ModeAddr = ADDR_W'(ModeBits);
  localparam logic [ADDR_W-1:0] PreAddr  = ADDR_W'(1024);

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdPre = 4'b0010;
  localparam logic [3:0] CmdRef = 4'b0001;
  localparam logic [3:0] CmdMrs = 4'b0000;

  if (T_PWRUP == 0 || T_RP == 0 || T_RFC == 0 || T_MRD == 0 || N_REF == 0) begin : g_chk_time
    $error("sdram_init_seq: T_PWRUP, T_RP, T_RFC, T_MRD and N_REF must be >= 1");
  end
  if (CAS_LAT != 2 && CAS_LAT != 3) begin : g_chk_cas
    $error("sdram_init_seq: CAS_LAT must be 2 or 3");
  end
  if (BURST_CODE > 3 && BURST_CODE != 7) begin : g_chk_burst
    $error("sdram_init_seq: BURST_CODE must be 0, 1, 2, 3 or 7");
  end
  if (ADDR_W < 11) begin : g_chk_addr
    $error("sdram_init_seq: ADDR_W must be >= 11");
  end

  typedef enum logic [3:0] {
    StIdle, StPwrup, StPre, StWaitRp, StRef, StWaitRfc, StMrs, StWaitMrd, StDone
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [RefW-1:0]   ref_q;
  logic [3:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BA_W-1:0]   ba_q;
  logic [1:0]        dqm_q;
  logic              fin_q;
  logic              busy_q;

  // Command states share the wait counter with their following wait state, so a
  // command plus its wait spans exactly T_x cycles and T_x = 1 needs no wait cycle.
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ref_q   <= '0;
      cmd_q   <= CmdNop;
      addr_q  <= '0;
      ba_q    <= '0;
      dqm_q   <= 2'b11;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cmd_q  <= CmdNop;
      addr_q <= '0;
      ba_q   <= '0;
      case (state_q)
        StIdle: begin
          if (ireq) begin
            state_q <= StPwrup;
            cnt_q   <= '0;
            ref_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StPwrup: begin
          if (cnt_q == PwrupLast) begin
            state_q <= StPre;
            cmd_q   <= CmdPre;
            addr_q  <= PreAddr;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StPre, StWaitRp: begin
          if (cnt_q == RpLast) begin
            state_q <= StRef;
            cmd_q   <= CmdRef;
            ref_q   <= ref_q + 1'b1;
            cnt_q   <= '0;
          end else begin
            state_q <= StWaitRp;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        StRef, StWaitRfc: begin
          if (cnt_q == RfcLast) begin
            cnt_q <= '0;
            if (ref_q < NRef) begin
              state_q <= StRef;
              cmd_q   <= CmdRef;
              ref_q   <= ref_q + 1'b1;
            end else begin
              state_q <= StMrs;
              cmd_q   <= CmdMrs;
              addr_q  <= ModeAddr;
            end
          end else begin
            state_q <= StWaitRfc;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        StMrs, StWaitMrd: begin
          if (cnt_q == MrdLast) begin
            state_q <= StDone;
            cnt_q   <= '0;
            dqm_q   <= 2'b00;
            fin_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StWaitMrd;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        StDone: begin
`ifdef SDRAM_INIT_REINIT_EN
          if (ireq) begin
            state_q <= StPre;
            cmd_q   <= CmdPre;
            addr_q  <= PreAddr;
            cnt_q   <= '0;
            ref_q   <= '0;
            dqm_q   <= 2'b11;
            fin_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ofin  = fin_q;
  assign obusy = busy_q;

  assign DRAM_CLK   = ienb ? ~iclk    : 1'bz;
  assign DRAM_CKE   = ienb ? 1'b1     : 1'bz;
  assign DRAM_ADDR  = ienb ? addr_q   : {ADDR_W{1'bz}};
  assign DRAM_BA    = ienb ? ba_q     : {BA_W{1'bz}};
  assign DRAM_CS_N  = ienb ? cmd_q[3] : 1'bz;
  assign DRAM_RAS_N = ienb ? cmd_q[2] : 1'bz;
  assign DRAM_CAS_N = ienb ? cmd_q[1] : 1'bz;
  assign DRAM_WE_N  = ienb ? cmd_q[0] : 1'bz;
  assign DRAM_LDQM  = ienb ? dqm_q[0] : 1'bz;
  assign DRAM_UDQM  = ienb ? dqm_q[1] : 1'bz;
  assign DRAM_DQ    = ienb ? {DQ_W{1'b0}} : {DQ_W{1'bz}};

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: a schedule model derived from the command timing rules is
// compared every cycle, plus literal checks of latencies and mode words.
module tb_sdram_init_seq;

  localparam int TP   = 10;
  localparam int TRP  = 2;
  localparam int TRFC = 7;
  localparam int NREF = 8;
  localparam int TMRD = 2;
  localparam int L    = TP + TRP + NREF * TRFC + TMRD;
  localparam int TREF0 = TP + TRP;
  localparam int TMRS  = TP + TRP + NREF * TRFC;

  localparam logic [12:0] Mode1 = 13'h220;
  localparam logic [12:0] Mode2 = 13'h03b;
  localparam logic [3:0]  CNop  = 4'b0111;
  localparam logic [3:0]  CPre  = 4'b0010;
  localparam logic [3:0]  CRef  = 4'b0001;
  localparam logic [3:0]  CMrs  = 4'b0000;

  logic iclk = 1'b0;
  logic ctr_reset = 1'b1;
  logic ireq = 1'b0;
  logic ienb = 1'b1;

  wire        ofin, obusy, d_clk, d_cke, d_cs, d_ras, d_cas, d_we, d_ldqm, d_udqm;
  wire [12:0] d_addr;
  wire [1:0]  d_ba;
  wire [15:0] d_dq;
  wire        ofin2, obusy2, e_clk, e_cke, e_cs, e_ras, e_cas, e_we, e_ldqm, e_udqm;
  wire [12:0] e_addr;
  wire [1:0]  e_ba;
  wire [15:0] e_dq;

  sdram_init_seq #(.T_PWRUP(TP), .T_RP(TRP), .T_RFC(TRFC), .N_REF(NREF), .T_MRD(TMRD)) dut (
    .iclk(iclk), .ctr_reset(ctr_reset), .ireq(ireq), .ienb(ienb), .ofin(ofin), .obusy(obusy),
    .DRAM_CLK(d_clk), .DRAM_CKE(d_cke), .DRAM_ADDR(d_addr), .DRAM_BA(d_ba),
    .DRAM_CS_N(d_cs), .DRAM_RAS_N(d_ras), .DRAM_CAS_N(d_cas), .DRAM_WE_N(d_we),
    .DRAM_LDQM(d_ldqm), .DRAM_UDQM(d_udqm), .DRAM_DQ(d_dq)
  );

  sdram_init_seq #(.T_PWRUP(TP), .T_RP(TRP), .T_RFC(TRFC), .N_REF(NREF), .T_MRD(TMRD),
                   .CAS_LAT(3), .BURST_CODE(3), .WRITE_SINGLE(0), .BURST_INTERLEAVE(1)) dut2 (
    .iclk(iclk), .ctr_reset(ctr_reset), .ireq(ireq), .ienb(ienb), .ofin(ofin2), .obusy(obusy2),
    .DRAM_CLK(e_clk), .DRAM_CKE(e_cke), .DRAM_ADDR(e_addr), .DRAM_BA(e_ba),
    .DRAM_CS_N(e_cs), .DRAM_RAS_N(e_ras), .DRAM_CAS_N(e_cas), .DRAM_WE_N(e_we),
    .DRAM_LDQM(e_ldqm), .DRAM_UDQM(e_udqm), .DRAM_DQ(e_dq)
  );

  always #5 iclk = ~iclk;

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the sequence is a fixed schedule indexed by phase p (cycles since the
  // first power-up cycle); re-init starts at phase TP.
  int cyc = 0;
  int start = 0;
  int off = 0;
  bit running = 1'b0;
  bit done_now;

  always @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      running = 1'b0;
    end else begin
      done_now = running && (cyc - start + off >= L);
      cyc++;
      if (!running && ireq) begin
        running = 1'b1;
        start = cyc;
        off = 0;
      end
`ifdef SDRAM_INIT_REINIT_EN
      else if (done_now && ireq) begin
        start = cyc;
        off = TP;
      end
`endif
    end
  end

  function automatic void model(input bit run, input int p, input logic [12:0] mode,
                                output logic [3:0] c, output logic [12:0] a,
                                output logic f, output logic b, output logic [1:0] d);
    c = CNop; a = '0; f = 1'b0; b = 1'b0; d = 2'b11;
    if (run) begin
      if (p >= L) begin
        f = 1'b1;
        d = 2'b00;
      end else begin
        b = 1'b1;
        if (p == TP) begin
          c = CPre;
          a = 13'h400;
        end else if (p >= TREF0 && p < TMRS && (p - TREF0) % TRFC == 0) begin
          c = CRef;
        end else if (p == TMRS) begin
          c = CMrs;
          a = mode;
        end
      end
    end
  endfunction

  bit          seen_pre;
  int          pre_k, first_ref_k, mrs_k, ref_seen;
  logic [12:0] pre_addr, mrs_addr, mrs2_addr;

  always @(negedge iclk) begin : cmp
    int p;
    logic [3:0]  ec, ec2, cmd, cmd2;
    logic [12:0] ea, ea2;
    logic        ef, eb, ef2, eb2;
    logic [1:0]  ed, ed2;
    logic        zok;
    p = cyc - start + off;
    model(running, p, Mode1, ec, ea, ef, eb, ed);
    model(running, p, Mode2, ec2, ea2, ef2, eb2, ed2);
    cmd  = {d_cs, d_ras, d_cas, d_we};
    cmd2 = {e_cs, e_ras, e_cas, e_we};
    check("ofin", ofin, ef);
    check("obusy", obusy, eb);
    check("ofin_busy2", {ofin2, obusy2}, {ef2, eb2});
    if (ienb) begin
      check("cmd", cmd, ec);
      check("addr", d_addr, ea);
      check("ba", d_ba, 0);
      check("dqm", {d_udqm, d_ldqm}, ed);
      check("cke_clk_dq", {d_cke, d_clk, d_dq}, {2'b11, 16'h0});
      check("cmd2", cmd2, ec2);
      check("addr2", e_addr, ea2);
      check("pins2", {e_clk, e_cke, e_ba, e_udqm, e_ldqm, e_dq}, {2'b11, 2'b00, ed2, 16'h0});
      if (running) begin
        if (cmd == CPre && !seen_pre) begin
          seen_pre = 1'b1;
          pre_k = p;
          pre_addr = d_addr;
        end
        if (cmd == CRef) begin
          if (ref_seen == 0) first_ref_k = p;
          ref_seen++;
        end
        if (cmd == CMrs) begin
          mrs_k = p;
          mrs_addr = d_addr;
        end
        if (cmd2 == CMrs) mrs2_addr = e_addr;
      end
    end else begin
      zok = (d_clk === 1'bz) && (d_cke === 1'bz) && (d_addr === 13'bz) && (d_ba === 2'bz) &&
            (d_cs === 1'bz) && (d_ras === 1'bz) && (d_cas === 1'bz) && (d_we === 1'bz) &&
            (d_ldqm === 1'bz) && (d_udqm === 1'bz) && (d_dq === 16'bz);
      check("pins_hiz", zok, 1);
    end
  end

  int pulse_cyc;

  task automatic tick();
    @(posedge iclk);
    #2;
  endtask

  task automatic clear_track();
    seen_pre = 1'b0; ref_seen = 0; pre_k = -1; first_ref_k = -1; mrs_k = -1;
    pre_addr = '0; mrs_addr = '1; mrs2_addr = '1;
  endtask

  task automatic pulse_req();
    ireq = 1'b1;
    tick();
    ireq = 1'b0;
    pulse_cyc = cyc;
  endtask

  task automatic wait_fin(output int lat);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ofin === 1'b1) begin
        lat = cyc - pulse_cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    ctr_reset = 1'b1;
    tick();
    tick();
    ctr_reset = 1'b0;
    tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    clear_track();
    repeat (3) tick();
    check("rst_cmd", {d_cs, d_ras, d_cas, d_we}, CNop);
    check("rst_addr_ba", {d_addr, d_ba}, 0);
    check("rst_dqm", {d_udqm, d_ldqm}, 2'b11);
    check("rst_fin_busy", {ofin, obusy}, 2'b00);
    ctr_reset = 1'b0;
    repeat (3) tick();

    // Full sequence; ireq toggles randomly mid-sequence and must be ignored.
    clear_track();
    pulse_req();
    for (int i = 0; i < 59; i++) begin
      ireq = 1'($urandom_range(0, 1));
      tick();
    end
    ireq = 1'b0;
    wait_fin(lat);
    check("fin_latency", lat, 70);
    check("pre_phase", pre_k, 10);
    check("pre_addr", pre_addr, 13'h400);
    check("ref_count", ref_seen, 8);
    check("first_ref_phase", first_ref_k, 12);
    check("mrs_phase", mrs_k, 68);
    check("mrs_addr", mrs_addr, 13'h220);
    check("mrs2_addr", mrs2_addr, 13'h03b);

    // ireq pulse while in DONE.
    repeat (5) tick();
    clear_track();
    pulse_req();
`ifdef SDRAM_INIT_REINIT_EN
    check("reinit_fin_low", {ofin, obusy}, 2'b01);
    check("reinit_pre", {d_cs, d_ras, d_cas, d_we}, CPre);
    wait_fin(lat);
    check("reinit_latency", lat, 60);
`else
    check("done_ignore", {ofin, obusy, d_cs, d_ras, d_cas, d_we}, {2'b10, CNop});
    repeat (20) tick();
    check("done_stays", ofin, 1);
`endif

    // Reset during the 4th REF, then a full rerun.
    do_reset();
    pulse_req();
    for (int i = 0; i < 100 && (cyc - start + off) != TREF0 + 3 * TRFC; i++) tick();
    check("ref4_phase", cyc - start + off, 33);
    check("ref4_cmd", {d_cs, d_ras, d_cas, d_we}, CRef);
    ctr_reset = 1'b1;
    #1;
    check("midrst_cmd", {d_cs, d_ras, d_cas, d_we}, CNop);
    check("midrst_dqm_fin", {d_udqm, d_ldqm, ofin, obusy}, 4'b1100);
    check("midrst_addr", d_addr, 0);
    tick();
    tick();
    ctr_reset = 1'b0;
    tick();
    clear_track();
    pulse_req();
    wait_fin(lat);
    check("rerun_latency", lat, 70);
    check("rerun_refs", ref_seen, 8);

    // Pin release mid-sequence, with random ienb in a window.
    do_reset();
    pulse_req();
    for (int i = 0; i < 60; i++) begin
      if (i >= 20 && i <= 25) ienb = 1'b0;
      else if (i > 25 && i <= 45) ienb = 1'($urandom_range(0, 1));
      else ienb = 1'b1;
      if (i == 22) begin
        #1;
        check("hiz_addr", d_addr === 13'bz, 1);
        check("hiz_dq_cke", (d_dq === 16'bz) && (d_cke === 1'bz), 1);
      end
      tick();
    end
    ienb = 1'b1;
    wait_fin(lat);
    check("ienb_latency", lat, 70);
    #1;
    check("enb_dq_cke", {d_dq, d_cke}, {16'h0, 1'b1});

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
